// File: rtl/config_access_ctrl.sv
// Qualifies the static-config bits of the RAM_IO config-access BELs and hands the
// settled mode word to the SoC over a valid/ack handshake, re-qualifying on later changes.
module config_access_ctrl #(
    parameter int NUM_TILES     = 4,
    parameter int BITS_PER_TILE = 4,
    parameter int STABLE_CYCLES = 8,
    parameter int MAX_RETRY     = 3
) (
    input  logic                               CLK,
    input  logic                               resetn,
    input  logic                               config_done,
    input  logic [NUM_TILES*BITS_PER_TILE-1:0] C_bits,
    output logic [NUM_TILES*BITS_PER_TILE-1:0] mode_word,
    output logic                               mode_valid,
    input  logic                               mode_ack,
    output logic                               busy,
    output logic                               err_unstable
);

    localparam int W       = NUM_TILES * BITS_PER_TILE;
    localparam int CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_PRESENT,
        S_DONE,
        S_ERROR
    } state_t;

    state_t             state;
    logic [W-1:0]       snapshot;
    logic [CNT_W-1:0]   cnt;
    logic [RETRY_W-1:0] retry;

    // Outputs are assigned together with each transition so they always reflect the next state.
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state        <= S_IDLE;
            mode_word    <= '0;
            mode_valid   <= 1'b0;
            busy         <= 1'b0;
            err_unstable <= 1'b0;
            snapshot     <= '0;
            cnt          <= '0;
            retry        <= '0;
        end else if (state != S_IDLE && !config_done) begin
            // Losing the configuration aborts everything, including an ack in this cycle.
            state        <= S_IDLE;
            mode_word    <= '0;
            mode_valid   <= 1'b0;
            busy         <= 1'b0;
            err_unstable <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (config_done) begin
                        state    <= S_SETTLE;
                        snapshot <= C_bits;
                        cnt      <= '0;
                        retry    <= '0;
                        busy     <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (C_bits == snapshot) begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                            state      <= S_PRESENT;
                            mode_word  <= snapshot;
                            mode_valid <= 1'b1;
                        end
                    end else if (retry == RETRY_W'(MAX_RETRY - 1)) begin
                        state        <= S_ERROR;
                        busy         <= 1'b0;
                        err_unstable <= 1'b1;
                    end else begin
                        snapshot <= C_bits;
                        cnt      <= '0;
                        retry    <= retry + RETRY_W'(1);
                    end
                end
                S_PRESENT: begin
                    if (mode_ack) begin
                        state      <= S_DONE;
                        mode_valid <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                S_DONE: begin
                    // A later change (partial reconfiguration) restarts qualification; the old word stays visible.
                    if (C_bits != mode_word) begin
                        state    <= S_SETTLE;
                        snapshot <= C_bits;
                        cnt      <= '0;
                        retry    <= '0;
                        busy     <= 1'b1;
                    end
                end
                S_ERROR: begin
                end
                default: begin
                    state        <= S_IDLE;
                    mode_word    <= '0;
                    mode_valid   <= 1'b0;
                    busy         <= 1'b0;
                    err_unstable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_config_access_ctrl.sv
// Directed, table-driven bench for config_access_ctrl with hand-written sequences
// for the unstable-input and reset-during-operation cases.
module tb_config_access_ctrl;

    logic        CLK = 1'b0;
    logic        resetn;
    logic        config_done;
    logic [15:0] C_bits;
    logic [15:0] mode_word;
    logic        mode_valid;
    logic        mode_ack;
    logic        busy;
    logic        err_unstable;

    int total = 0;
    int bad   = 0;

    config_access_ctrl #(
        .NUM_TILES    (4),
        .BITS_PER_TILE(4),
        .STABLE_CYCLES(8),
        .MAX_RETRY    (3)
    ) dut (
        .CLK         (CLK),
        .resetn      (resetn),
        .config_done (config_done),
        .C_bits      (C_bits),
        .mode_word   (mode_word),
        .mode_valid  (mode_valid),
        .mode_ack    (mode_ack),
        .busy        (busy),
        .err_unstable(err_unstable)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          n;
        logic        cd;
        logic        ack;
        logic [15:0] c;
        logic        ev;
        logic [15:0] ew;
        logic        eb;
        logic        ee;
    } vec_t;

    localparam int NV = 16;
    vec_t tbl[NV];

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [15:0] ew,
                           input logic eb, input logic ee);
        chk({tag, ".mode_valid"}, {15'd0, mode_valid}, {15'd0, ev});
        chk({tag, ".mode_word"}, mode_word, ew);
        chk({tag, ".busy"}, {15'd0, busy}, {15'd0, eb});
        chk({tag, ".err_unstable"}, {15'd0, err_unstable}, {15'd0, ee});
    endtask

    initial begin
        //          n   cd    ack   C_bits    valid word      busy  err
        // stable bring-up: T, T+1..T+7, T+8, 20-cycle hold, ack, idle in DONE
        tbl[0]  = '{1,  1'b1, 1'b0, 16'hA5C3, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[1]  = '{7,  1'b1, 1'b0, 16'hA5C3, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2]  = '{1,  1'b1, 1'b0, 16'hA5C3, 1'b1, 16'hA5C3, 1'b1, 1'b0};
        tbl[3]  = '{20, 1'b1, 1'b0, 16'hA5C3, 1'b1, 16'hA5C3, 1'b1, 1'b0};
        tbl[4]  = '{1,  1'b1, 1'b1, 16'hA5C3, 1'b0, 16'hA5C3, 1'b0, 1'b0};
        tbl[5]  = '{3,  1'b1, 1'b0, 16'hA5C3, 1'b0, 16'hA5C3, 1'b0, 1'b0};
        // partial reconfig from DONE; ack during SETTLE must be ignored
        tbl[6]  = '{1,  1'b1, 1'b0, 16'h0F0F, 1'b0, 16'hA5C3, 1'b1, 1'b0};
        tbl[7]  = '{7,  1'b1, 1'b1, 16'h0F0F, 1'b0, 16'hA5C3, 1'b1, 1'b0};
        tbl[8]  = '{1,  1'b1, 1'b0, 16'h0F0F, 1'b1, 16'h0F0F, 1'b1, 1'b0};
        // abort: config_done falls together with ack
        tbl[9]  = '{1,  1'b0, 1'b1, 16'h0F0F, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[10] = '{2,  1'b0, 1'b0, 16'hA5C3, 1'b0, 16'h0000, 1'b0, 1'b0};
        // glitch restart: mismatch sampled at T+4
        tbl[11] = '{4,  1'b1, 1'b0, 16'hA5C3, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[12] = '{8,  1'b1, 1'b0, 16'hA5C2, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[13] = '{1,  1'b1, 1'b0, 16'hA5C2, 1'b1, 16'hA5C2, 1'b1, 1'b0};
        tbl[14] = '{1,  1'b1, 1'b1, 16'hA5C2, 1'b0, 16'hA5C2, 1'b0, 1'b0};
        tbl[15] = '{1,  1'b0, 1'b0, 16'hA5C2, 1'b0, 16'h0000, 1'b0, 1'b0};

        resetn      = 1'b0;
        config_done = 1'b1;
        mode_ack    = 1'b1;
        C_bits      = 16'hFFFF;
        step(2);
        chk_all("reset", 1'b0, 16'h0000, 1'b0, 1'b0);

        resetn      = 1'b1;
        config_done = 1'b0;
        mode_ack    = 1'b0;
        step(1);
        chk_all("idle", 1'b0, 16'h0000, 1'b0, 1'b0);

        for (int i = 0; i < NV; i++) begin
            config_done = tbl[i].cd;
            mode_ack    = tbl[i].ack;
            C_bits      = tbl[i].c;
            step(tbl[i].n);
            chk_all($sformatf("row%0d", i), tbl[i].ev, tbl[i].ew, tbl[i].eb, tbl[i].ee);
        end

        // Unstable: a new value every edge from T; the third mismatch (T+3) lands in ERROR.
        config_done = 1'b1;
        mode_ack    = 1'b0;
        for (int i = 0; i < 6; i++) begin
            C_bits = 16'h1000 + 16'(i);
            step(1);
            chk_all($sformatf("unstable%0d", i), 1'b0, 16'h0000, (i < 3), (i >= 3));
        end
        mode_ack = 1'b1;
        step(2);
        chk_all("error_hold", 1'b0, 16'h0000, 1'b0, 1'b1);
        mode_ack    = 1'b0;
        config_done = 1'b0;
        step(1);
        chk_all("error_exit", 1'b0, 16'h0000, 1'b0, 1'b0);

        // Reset at T+3 in SETTLE, then re-qualification from T'.
        config_done = 1'b1;
        C_bits      = 16'h1234;
        step(3);
        chk_all("pre_reset_settle", 1'b0, 16'h0000, 1'b1, 1'b0);
        resetn = 1'b0;
        step(1);
        chk_all("reset_settle", 1'b0, 16'h0000, 1'b0, 1'b0);
        resetn = 1'b1;
        step(8);
        chk_all("requal_wait", 1'b0, 16'h0000, 1'b1, 1'b0);
        step(1);
        chk_all("requal_valid", 1'b1, 16'h1234, 1'b1, 1'b0);

        // Reset while presenting, with ack raised on the same edge: no transfer, all cleared.
        mode_ack = 1'b1;
        resetn   = 1'b0;
        step(1);
        chk_all("reset_present", 1'b0, 16'h0000, 1'b0, 1'b0);
        mode_ack = 1'b0;
        resetn   = 1'b1;
        C_bits   = 16'h4321;
        step(8);
        chk_all("requal2_wait", 1'b0, 16'h0000, 1'b1, 1'b0);
        step(1);
        chk_all("requal2_valid", 1'b1, 16'h4321, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
